// File: rtl/ntt_pkg.sv
// ============================================================================
// ntt_pkg : shared NTT word/index types, default sizes and bit reversal.
// Revision: 1.0
// ============================================================================
`default_nettype none

package ntt_pkg;

  localparam int NTT_W     = 32;
  localparam int NTT_N     = 8;
  localparam int NTT_LOG2N = $clog2(NTT_N);

  typedef logic [NTT_W-1:0]     coef_t;
  typedef logic [NTT_LOG2N-1:0] idx_t;

  function automatic idx_t bitrev(input idx_t idx);
    idx_t r;
    r = '0;
    for (int i = 0; i < NTT_LOG2N; i++) begin
      r[i] = idx[NTT_LOG2N-1-i];
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ntt_reorder_bank.sv
// ============================================================================
// ntt_reorder_bank : N x W register bank, synchronous write, async read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_reorder_bank
  import ntt_pkg::*;
#(
  parameter int W     = NTT_W,
  parameter int N     = NTT_N,
  parameter int LOG2N = $clog2(N)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [LOG2N-1:0] waddr,
  input  logic [W-1:0]     wdata,
  input  logic [LOG2N-1:0] raddr,
  output logic [W-1:0]     rdata
);

  // Contents are intentionally not reset; validity is tracked by the owner.
  logic [W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

`default_nettype wire

// File: rtl/ntt_bitrev_reorder.sv
// ============================================================================
// ntt_bitrev_reorder : ping-pong reorder of bit-reversed NTT frames into
// natural order, with output valid/ready and sticky overflow.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ntt_bitrev_reorder
  import ntt_pkg::*;
#(
  parameter int W = NTT_W,
  parameter int N = NTT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_last,
  output logic         overflow
);

  localparam int LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  logic             wr_bank;
  logic [LOG2N-1:0] wr_idx;
  logic             rd_bank;
  logic [LOG2N-1:0] rd_idx;
  logic [1:0]       full;
  logic             overflow_q;

  logic             accept;
  logic             drop;
  logic             xfer;
  logic [LOG2N-1:0] raddr;
  logic [W-1:0]     rdata [2];

  assign accept = in_valid && !full[wr_bank];
  assign drop   = in_valid &&  full[wr_bank];
  assign xfer   = full[rd_bank] && out_ready;

  always_comb begin
    raddr = '0;
    for (int i = 0; i < LOG2N; i++) begin
      raddr[i] = rd_idx[LOG2N-1-i];
    end
  end

  genvar b;
  generate
    for (b = 0; b < 2; b++) begin : g_bank
      ntt_reorder_bank #(
        .W     (W),
        .N     (N),
        .LOG2N (LOG2N)
      ) u_bank (
        .clk   (clk),
        .we    (accept && (wr_bank == 1'(b))),
        .waddr (wr_idx),
        .wdata (in_data),
        .raddr (raddr),
        .rdata (rdata[b])
      );
    end
  endgenerate

  // A frame completing on the write side and one draining on the read side
  // always refer to different banks, so both full-flag updates can coexist.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_bank    <= 1'b0;
      wr_idx     <= '0;
      rd_bank    <= 1'b0;
      rd_idx     <= '0;
      full       <= 2'b00;
      overflow_q <= 1'b0;
    end else begin
      if (accept) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == LAST_IDX) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (xfer) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_idx == LAST_IDX) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
        end
      end
    end
  end

  assign out_valid = full[rd_bank];
  assign out_data  = rdata[rd_bank];
  assign out_last  = out_valid && (rd_idx == LAST_IDX);
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_ntt_bitrev_reorder.sv
// ============================================================================
// tb_ntt_bitrev_reorder : directed self-checking bench for ntt_bitrev_reorder.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_ntt_bitrev_reorder;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic        overflow;

  int n_cmp;
  int n_err;

  // snapshot of outputs taken at the falling edge of the current cycle
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ovf;
  int          cnum;

  int got[$];
  int got_cyc[$];
  bit got_last[$];

  ntt_bitrev_reorder #(.W(32), .N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(negedge clk);
    s_data  = out_data;
    s_valid = out_valid;
    s_last  = out_last;
    s_ovf   = overflow;
    if (out_valid && out_ready) begin
      got.push_back(int'(out_data));
      got_cyc.push_back(cnum);
      got_last.push_back(out_last);
    end
    cnum++;
    @(posedge clk);
    #1;
  endtask

  task automatic start_test();
    rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b0);
    rst = 1'b1;
    got.delete();
    got_cyc.delete();
    got_last.delete();
    cnum = 0;
  endtask

  task automatic test_reset();
    start_test();
    cyc(1'b0, 32'd0, 1'b1);
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", s_valid); end
    n_cmp++; if (s_last  !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", s_last); end
    n_cmp++; if (s_ovf   !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", s_ovf); end
  endtask

  task automatic test_single_frame();
    int exp_v[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    start_test();
    for (int c = 0; c < 20; c++) cyc(c < 8, 32'(c), 1'b1);
    n_cmp++;
    if (got.size() != 8) begin
      n_err++; $display("FAIL single_count: got %0d want 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (got[k] != exp_v[k] || got_cyc[k] != 8 + k || got_last[k] != (k == 7)) begin
          n_err++;
          $display("FAIL single_out[%0d]: got data=%0d cyc=%0d last=%0d want data=%0d cyc=%0d last=%0d",
                   k, got[k], got_cyc[k], got_last[k], exp_v[k], 8 + k, (k == 7));
        end
      end
    end
    n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b want 0", s_ovf); end
  endtask

  task automatic test_back_to_back();
    int exp_v[16] = '{0, 4, 2, 6, 1, 5, 3, 7, 10, 14, 12, 16, 11, 15, 13, 17};
    start_test();
    for (int c = 0; c < 30; c++) cyc(c < 16, (c < 8) ? 32'(c) : 32'(c + 2), 1'b1);
    n_cmp++;
    if (got.size() != 16) begin
      n_err++; $display("FAIL b2b_count: got %0d want 16", got.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (got[k] != exp_v[k] || got_cyc[k] != 8 + k || got_last[k] != (k == 7 || k == 15)) begin
          n_err++;
          $display("FAIL b2b_out[%0d]: got data=%0d cyc=%0d last=%0d want data=%0d cyc=%0d",
                   k, got[k], got_cyc[k], got_last[k], exp_v[k], 8 + k);
        end
      end
    end
    n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b want 0", s_ovf); end
  endtask

  task automatic test_backpressure();
    int exp_v[16] = '{0, 4, 2, 6, 1, 5, 3, 7, 10, 14, 12, 16, 11, 15, 13, 17};
    logic        r;
    logic        p_stall;
    logic [31:0] p_data;
    logic        p_last;
    start_test();
    p_stall = 1'b0;
    p_data  = '0;
    p_last  = 1'b0;
    for (int c = 0; c < 60; c++) begin
      r = (c < 8 || c >= 40) ? 1'b1 : c[0];
      cyc(c < 16, (c < 8) ? 32'(c) : 32'(c + 2), r);
      if (p_stall) begin
        n_cmp++;
        if (s_valid !== 1'b1 || s_data !== p_data || s_last !== p_last) begin
          n_err++;
          $display("FAIL bp_stable@%0d: got v=%b d=%0d l=%b want v=1 d=%0d l=%b",
                   c, s_valid, s_data, s_last, p_data, p_last);
        end
      end
      p_stall = s_valid && !r;
      p_data  = s_data;
      p_last  = s_last;
    end
    n_cmp++;
    if (got.size() != 16) begin
      n_err++; $display("FAIL bp_count: got %0d want 16", got.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (got[k] != exp_v[k]) begin
          n_err++; $display("FAIL bp_out[%0d]: got %0d want %0d", k, got[k], exp_v[k]);
        end
      end
    end
    n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL bp_ovf: got %b want 0", s_ovf); end
  endtask

  task automatic test_overflow();
    int exp_v[16] = '{0, 4, 2, 6, 1, 5, 3, 7, 8, 12, 10, 14, 9, 13, 11, 15};
    start_test();
    for (int c = 0; c < 17; c++) cyc(1'b1, 32'(c), 1'b0);
    n_cmp++; if (s_ovf !== 1'b0) begin n_err++; $display("FAIL ovf_early: got %b want 0", s_ovf); end
    cyc(1'b0, 32'd0, 1'b0);
    n_cmp++; if (s_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_set: got %b want 1", s_ovf); end
    for (int c = 0; c < 24; c++) cyc(1'b0, 32'd0, 1'b1);
    n_cmp++;
    if (got.size() != 16) begin
      n_err++; $display("FAIL ovf_count: got %0d want 16", got.size());
    end else begin
      for (int k = 0; k < 16; k++) begin
        n_cmp++;
        if (got[k] != exp_v[k]) begin
          n_err++; $display("FAIL ovf_out[%0d]: got %0d want %0d", k, got[k], exp_v[k]);
        end
      end
    end
    n_cmp++; if (s_ovf !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b want 1", s_ovf); end
  endtask

  task automatic test_gaps();
    int exp_v[8] = '{0, 4, 2, 6, 1, 5, 3, 7};
    int first_v;
    start_test();
    first_v = -1;
    for (int c = 0; c < 32; c++) begin
      cyc(c < 16 && !c[0], 32'(c / 2), 1'b1);
      if (s_valid && first_v < 0) first_v = c;
    end
    n_cmp++; if (first_v != 15) begin n_err++; $display("FAIL gap_first_valid: got cycle %0d want 15", first_v); end
    n_cmp++;
    if (got.size() != 8) begin
      n_err++; $display("FAIL gap_count: got %0d want 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (got[k] != exp_v[k]) begin
          n_err++; $display("FAIL gap_out[%0d]: got %0d want %0d", k, got[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_mid_reset();
    int exp_v[8] = '{20, 24, 22, 26, 21, 25, 23, 27};
    start_test();
    for (int c = 0; c < 5; c++) cyc(1'b1, 32'(c + 100), 1'b1);
    rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 32'd0, 1'b1);
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rst1_valid: got %b want 0", s_valid); end
    for (int c = 0; c < 17; c++) cyc(1'b1, 32'(c + 200), 1'b0);
    for (int c = 0; c < 3; c++) cyc(1'b0, 32'd0, 1'b1);
    rst = 1'b0;
    cyc(1'b0, 32'd0, 1'b1);
    rst = 1'b1;
    cyc(1'b0, 32'd0, 1'b1);
    n_cmp++; if (s_valid !== 1'b0) begin n_err++; $display("FAIL rst2_valid: got %b want 0", s_valid); end
    n_cmp++; if (s_ovf   !== 1'b0) begin n_err++; $display("FAIL rst2_ovf: got %b want 0", s_ovf); end
    got.delete();
    got_cyc.delete();
    got_last.delete();
    for (int c = 0; c < 20; c++) cyc(c < 8, 32'(c + 20), 1'b1);
    n_cmp++;
    if (got.size() != 8) begin
      n_err++; $display("FAIL rst_frame_count: got %0d want 8", got.size());
    end else begin
      for (int k = 0; k < 8; k++) begin
        n_cmp++;
        if (got[k] != exp_v[k]) begin
          n_err++; $display("FAIL rst_frame_out[%0d]: got %0d want %0d", k, got[k], exp_v[k]);
        end
      end
    end
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    cnum      = 0;
    rst       = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_backpressure();
    test_overflow();
    test_gaps();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
